spi_target_framed: RTL

SPI_TARGET_FRAMED -- requirements
Module: spi_target_framed

---
 rtl/spi_pkg.sv | 8 +
 rtl/spi_sync_edge.sv | 29 ++
 rtl/spi_target_framed.sv | 120 ++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: FSM state encoding and SPI mode constants ({CKP,CPH}) shared by the framed SPI target.
package spi_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchroniser for an asynchronous input with one-cycle rise/fall pulses.
module spi_sync_edge #(
  parameter int   STAGES = 2,
  parameter logic INIT   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync;
  logic              prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= {STAGES{INIT}};
      prev <= INIT;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      prev <= sync[STAGES-1];
    end
  end

  assign q    = sync[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;
endmodule

// File: rtl/spi_target_framed.sv
// spi_target_framed: SPI target that moves DATA_W-bit words per SS frame, with a tx holding register,
// back-to-back words under one SS, and abort/underrun reporting on frame_err.
module spi_target_framed
  import spi_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter bit LSB_FIRST   = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CKP,
  input  logic              CPH,
  input  logic              SS,
  input  logic              SCK,
  input  logic              MOSI,
  output logic              MISO,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              frame_err
);
  localparam int CW = $clog2(DATA_W);

  state_t                 state, state_nx;
  logic                   ss_s, ss_rise, ss_fall, sck_s, sck_rise, sck_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   ckp_l, cph_l, pend, urun;
  logic [DATA_W-1:0]      sr, rx_sr, hold, next_word, rx_nx;
  logic [CW-1:0]          cnt;
  logic                   sck_edge, lead, trail, in_shift, samp, launch, reload, take, last, abort;

  function automatic logic first_bit(input logic [DATA_W-1:0] x);
    return LSB_FIRST ? x[0] : x[DATA_W-1];
  endfunction

  spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_ss (
    .clk(clk), .rst(rst), .d(SS), .q(ss_s), .rise(ss_rise), .fall(ss_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sck (
    .clk(clk), .rst(rst), .d(SCK), .q(sck_s), .rise(sck_rise), .fall(sck_fall)
  );

  assign sck_edge  = sck_rise | sck_fall;
  assign lead      = sck_edge && (sck_s != ckp_l);
  assign trail     = sck_edge && (sck_s == ckp_l);
  assign in_shift  = state == SHIFT && !ss_s;
  assign samp      = in_shift && (cph_l ? trail : lead);
  assign launch    = in_shift && (cph_l ? lead : trail);
  // A launch edge right after a completed word starts the next word from the holding register
  assign reload    = state == LOAD || (launch && pend);
  assign take      = tx_load && (tx_ready || reload);
  assign next_word = tx_ready ? '0 : hold;
  assign rx_nx     = LSB_FIRST ? {mosi_sync[SYNC_STAGES-1], rx_sr[DATA_W-1:1]}
                               : {rx_sr[DATA_W-2:0], mosi_sync[SYNC_STAGES-1]};
  assign last      = cnt == CW'(DATA_W - 1);
  assign abort     = state == SHIFT && ss_rise && cnt != '0;
  assign busy      = state != IDLE;
  assign MISO      = ss_s ? 1'b0 : state == LOAD ? first_bit(next_word) : state == SHIFT ? first_bit(sr) : 1'b0;

  always_comb begin
    state_nx = state == IDLE ? (ss_fall ? LOAD : IDLE) : state == LOAD ? SHIFT : (ss_s ? IDLE : SHIFT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mosi_sync <= '0;
      ckp_l     <= 1'b0;
      cph_l     <= 1'b0;
      sr        <= '0;
      rx_sr     <= '0;
      hold      <= '0;
      tx_ready  <= 1'b1;
      cnt       <= '0;
      pend      <= 1'b0;
      urun      <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      rx_valid  <= samp && last;
      // A back-to-back underrun is only reported once the new word actually gets sampled
      frame_err <= (state == LOAD && tx_ready) || abort || (samp && urun);
      if (state == IDLE) begin
        ckp_l <= CKP;
        cph_l <= CPH;
      end
      if (reload) sr <= next_word;
      else if (launch && cnt != '0) sr <= LSB_FIRST ? sr >> 1 : sr << 1;
      if (take) begin
        hold     <= tx_data;
        tx_ready <= 1'b0;
      end else if (reload) tx_ready <= 1'b1;
      if (state != SHIFT) begin
        cnt  <= '0;
        pend <= 1'b0;
        urun <= 1'b0;
      end else if (samp) begin
        rx_sr <= rx_nx;
        cnt   <= last ? '0 : cnt + 1'b1;
        pend  <= last;
        urun  <= 1'b0;
        if (last) rx_data <= rx_nx;
      end else if (launch) begin
        pend <= 1'b0;
        if (pend) urun <= tx_ready;
      end
    end
  end
endmodule
